mult_seq: RTL and testbench

- Sequential signed multiplier. It is the companion to the iterative divider in the multdiv unit and computes the forward operation that division inverts.
- Uses radix-2 Booth recoding over a 65-bit product/shift register, driven by a 6-bit iteration counter.
- Launched by a one-cycle ctrl_MULT pulse from the multdiv control.
- Returns a 32-bit product, an overflow exception flag and a one-cycle ready strobe.

---
 rtl/mult_seq.sv | 132 +++++++++++++
 tb/tb_mult_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Sequential signed multiplier, radix-2 Booth recoding.
// One Booth step per clock over a (2*WIDTH+1)-bit product/shift register.
// A start pulse in any state (re)loads the operands. Results are registered:
// prod/exceptRes update together with the one-cycle resultRDY strobe and
// then hold until the next completed operation or reset.
//
// Handshake: ctrl_MULT is a single-cycle request that is always accepted,
// with no ready back-pressure. resultRDY is a single-cycle valid that the
// consumer cannot stall. busy is high while Booth steps are executing.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] prod,
  output logic             exceptRes,
  output logic             resultRDY,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    preg_q, preg_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   upper_ext;
  logic [WIDTH:0]   mc_ext;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    step;

  // Booth step: add/subtract the sign-extended multiplicand into the upper
  // half, then arithmetic-shift right by one. The extra sum bit becomes the
  // new top bit, so a 0x80000000 multiplicand never loses its sign.
  always_comb begin
    upper_ext = {preg_q[PW-1], preg_q[PW-1:WIDTH+1]};
    mc_ext    = {mreg_q[WIDTH-1], mreg_q};
    case (preg_q[1:0])
      2'b01:   sum = upper_ext + mc_ext;
      2'b10:   sum = upper_ext - mc_ext;
      default: sum = upper_ext;
    endcase
    step = {sum, preg_q[WIDTH:1]};
  end

  // Next-state logic: start/restart load, step sequencing and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    preg_d  = preg_q;
    mreg_d  = mreg_q;
    prod_d  = prod_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    if (ctrl_MULT) begin
      // A start in any state aborts whatever is running.
      mreg_d  = mcand;
      preg_d  = {{WIDTH{1'b0}}, mplier, 1'b0};
      cnt_d   = '0;
      state_d = RUN;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          preg_d = step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
          end
        end
        DONE: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          prod_d  = preg_q[WIDTH:1];
          // Upper half must be pure sign extension of the low half.
          exc_d   = (preg_q[PW-1:WIDTH+1] != {WIDTH{preg_q[WIDTH]}});
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      preg_q  <= '0;
      mreg_q  <= '0;
      prod_q  <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      preg_q  <= preg_d;
      mreg_q  <= mreg_d;
      prod_q  <= prod_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign prod      = prod_q;
  assign exceptRes = exc_q;
  assign resultRDY = rdy_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: hand-computed products, latency, busy width,
// restart and mid-run reset behaviour.
module tb_mult_seq;

  logic        clk;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] prod;
  logic        exceptRes;
  logic        resultRDY;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic [32:0] exp_q[$];

  mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ctrl_MULT (ctrl_MULT),
    .mcand     (mcand),
    .mplier    (mplier),
    .prod      (prod),
    .exceptRes (exceptRes),
    .resultRDY (resultRDY),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resultRDY === 1'b1) strobe_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle start pulse, sampled on the posedge in between
  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mcand     = a;
    mplier    = b;
    ctrl_MULT = 1'b1;
    @(negedge clk);
    ctrl_MULT = 1'b0;
  endtask

  // wait for resultRDY after a pulse; check latency, busy width, scoreboard
  task automatic wait_result(input string tag);
    int n;
    int busy_n;
    logic [32:0] e;
    n = 0;
    busy_n = (busy === 1'b1) ? 1 : 0;
    while (resultRDY !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) busy_n++;
    end
    check_val({tag, "_latency"}, n, 33);
    check_val({tag, "_busy_cycles"}, busy_n, 32);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (resultRDY === 1'b1) begin
        check_val({tag, "_prod"}, prod, e[31:0]);
        check_val({tag, "_exc"}, {31'b0, exceptRes}, {31'b0, e[32]});
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ep, input logic ee);
    int s0;
    s0 = strobe_cnt;
    exp_q.push_back({ee, ep});
    pulse(a, b);
    wait_result(tag);
    @(negedge clk);
    #1;
    check_val({tag, "_strobe_1cyc"}, {31'b0, resultRDY}, 32'd0);
    check_val({tag, "_prod_hold"}, prod, ep);
    check_val({tag, "_strobes"}, strobe_cnt - s0, 1);
  endtask

  initial begin
    int s0;
    reset_n   = 1'b0;
    ctrl_MULT = 1'b0;
    mcand     = '0;
    mplier    = '0;
    repeat (3) @(negedge clk);
    check_val("rst_prod", prod, 32'd0);
    check_val("rst_exc", {31'b0, exceptRes}, 32'd0);
    check_val("rst_rdy", {31'b0, resultRDY}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("six_seven", 32'd6, 32'd7, 32'h0000002A, 1'b0);
    run_op("m3_x_5", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0);
    run_op("5_x_m3", 32'd5, 32'hFFFFFFFD, 32'hFFFFFFF1, 1'b0);
    run_op("max_x_2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1);
    run_op("min_x_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("min_x_min", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    run_op("min_x_1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op("zero_x", 32'd0, 32'h12345678, 32'h00000000, 1'b0);

    // restart: first operation aborted, only the second one strobes
    s0 = strobe_cnt;
    pulse(32'd100, 32'd100);
    repeat (9) @(negedge clk);
    exp_q.push_back({1'b0, 32'hFFFFFFAF});
    pulse(32'd9, 32'hFFFFFFF7);
    wait_result("restart");
    @(negedge clk);
    #1;
    check_val("restart_strobes", strobe_cnt - s0, 1);

    // reset mid-run: outputs clear before the next edge, no late strobe
    pulse(32'd100, 32'd100);
    repeat (14) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("midrst_prod", prod, 32'd0);
    check_val("midrst_busy", {31'b0, busy}, 32'd0);
    check_val("midrst_rdy", {31'b0, resultRDY}, 32'd0);
    s0 = strobe_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_val("midrst_no_strobe", strobe_cnt - s0, 0);
    check_val("midrst_idle_busy", {31'b0, busy}, 32'd0);
    run_op("after_rst", 32'd6, 32'd7, 32'h0000002A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
